// File: rtl/rr_packet_arbiter.sv
// rtl/rr_packet_arbiter.sv - round-robin packet-locking arbiter driving a shared mux select
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        per-source beat valid (bit i = mux input i)
//   last       per-source end-of-packet flag, used only with the granted source's transfer
//   ready_in   downstream accepts the mux output this cycle
//   select     registered binary mux select
//   grant      registered one-hot of select while locked, zero when idle
//   valid_out  mux output beat valid
//   ready_out  per-source accept, grant & ready_in
//   busy       high while a packet owns the datapath

module rr_packet_arbiter #(
  parameter int DEPTH     = 4,
  parameter int SEL_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DEPTH-1:0]     req,
  input  logic [DEPTH-1:0]     last,
  input  logic                 ready_in,
  output logic [SEL_WIDTH-1:0] select,
  output logic [DEPTH-1:0]     grant,
  output logic                 valid_out,
  output logic [DEPTH-1:0]     ready_out,
  output logic                 busy
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state, state_nxt;
  logic [SEL_WIDTH-1:0] ptr, ptr_nxt, sel_nxt;
  logic [DEPTH-1:0]     grant_nxt;
  logic [SEL_WIDTH-1:0] idx, win;
  logic                 found;
  logic                 last_sel;
  logic                 xfer;

  // grant is zero outside LOCKED, so masking with it both selects the owner
  // and suppresses the handshakes while idle.
  assign valid_out = |(req & grant);
  assign last_sel  = |(last & grant);
  assign ready_out = grant & {DEPTH{ready_in}};
  assign xfer      = valid_out & ready_in;
  assign busy      = (state == LOCKED);

  // Scan ptr+1, ptr+2, ... wrapping at DEPTH-1 (not at 2^SEL_WIDTH) so that
  // non-power-of-two DEPTH never probes a nonexistent source.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = ptr;
    for (int k = 0; k < DEPTH; k++) begin
      idx = (idx == SEL_WIDTH'(DEPTH - 1)) ? '0 : idx + SEL_WIDTH'(1);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = select;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = LOCKED;
          sel_nxt   = win;
          grant_nxt = DEPTH'(1) << win;
        end
      end
      LOCKED: begin
        // Gaps and non-last beats keep the lock; only the owner's last beat releases it.
        if (xfer && last_sel) begin
          state_nxt = IDLE;
          ptr_nxt   = select;
          grant_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      select <= '0;
      ptr    <= SEL_WIDTH'(DEPTH - 1);
      grant  <= '0;
    end else begin
      state  <= state_nxt;
      select <= sel_nxt;
      ptr    <= ptr_nxt;
      grant  <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// tb/tb_rr_packet_arbiter.sv - scoreboard bench for rr_packet_arbiter

module tb_rr_packet_arbiter;

  localparam int DEPTH = 4;
  localparam int SW    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DEPTH-1:0] req = '0;
  logic [DEPTH-1:0] last = '0;
  logic             ready_in = 1'b0;
  logic [SW-1:0]    select;
  logic [DEPTH-1:0] grant;
  logic             valid_out;
  logic [DEPTH-1:0] ready_out;
  logic             busy;

  rr_packet_arbiter #(.DEPTH(DEPTH), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .ready_in(ready_in),
    .select(select), .grant(grant), .valid_out(valid_out),
    .ready_out(ready_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             busy;
    int               sel;
    logic [DEPTH-1:0] grant;
    logic             valid;
    logic [DEPTH-1:0] rdy;
  } cyc_t;

  typedef struct {
    int   src;
    logic lst;
  } xfer_t;

  cyc_t  cyc_q[$];
  xfer_t xfer_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: owner = source holding the packet (-1 when idle).
  int owner = -1;
  int mptr  = DEPTH - 1;
  int msel  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    mptr  = DEPTH - 1;
    msel  = 0;
    cyc_q.delete();
    xfer_q.delete();
  endtask

  // Predict this cycle's outputs from the model state, then advance the model
  // across the coming clock edge.
  task automatic model_step();
    cyc_t  e;
    xfer_t x;
    e.busy  = (owner >= 0);
    e.sel   = msel;
    e.grant = '0;
    e.valid = 1'b0;
    e.rdy   = '0;
    if (owner >= 0) begin
      e.grant[owner] = 1'b1;
      e.valid = req[owner];
      if (ready_in) e.rdy = e.grant;
    end
    cyc_q.push_back(e);
    if (owner < 0) begin
      for (int k = 1; k <= DEPTH; k++) begin
        if (owner < 0 && req[(mptr + k) % DEPTH]) begin
          owner = (mptr + k) % DEPTH;
          msel  = owner;
        end
      end
    end else if (req[owner] && ready_in) begin
      x.src = owner;
      x.lst = last[owner];
      xfer_q.push_back(x);
      if (last[owner]) begin
        mptr  = owner;
        owner = -1;
      end
    end
  endtask

  task automatic cycle(input logic [DEPTH-1:0] r, input logic [DEPTH-1:0] l, input logic rd);
    @(posedge clk);
    #1;
    req      = r;
    last     = l;
    ready_in = rd;
    model_step();
  endtask

  // Called at posedge+1; reset lands mid-cycle to exercise the async path.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_ready_out", int'(ready_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_select", int'(select), 0);
    model_reset();
    req = '0;
    last = '0;
    ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops a cycle record every cycle that has one, and a transfer
  // record whenever the DUT shows a completed handshake.
  always @(negedge clk) begin
    cyc_t  e;
    xfer_t x;
    if (!rst) begin
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        chk("busy", int'(busy), int'(e.busy));
        chk("grant", int'(grant), int'(e.grant));
        chk("valid_out", int'(valid_out), int'(e.valid));
        chk("ready_out", int'(ready_out), int'(e.rdy));
        if (e.busy) chk("select", int'(select), e.sel);
        else if (e.sel >= 0) chk("select_idle", int'(select), e.sel);
      end
      if (valid_out && ready_in) begin
        if (xfer_q.size() == 0) begin
          chk("xfer_unexpected", 1, 0);
        end else begin
          x = xfer_q.pop_front();
          chk("xfer_src", int'(select), x.src);
          chk("xfer_last", int'(last[select]), int'(x.lst));
        end
      end
    end
  end

  initial begin
    logic [DEPTH-1:0] r, l;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_grant", int'(grant), 0);
    chk("reset_select", int'(select), 0);
    rst = 1'b0;

    // Idle with no requests.
    repeat (5) cycle(4'b0000, 4'b0000, 1'b1);

    // All request, single-beat packets: order 0,1,2,3,0.
    repeat (10) cycle(4'b1111, 4'b1111, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1);

    // Source 1 packet so source 2 is next in line.
    cycle(4'b0010, 4'b0010, 1'b1);
    cycle(4'b0010, 4'b0010, 1'b1);

    // Source 2 three-beat packet with ready toggling; source 0 next.
    cycle(4'b0111, 4'b0000, 1'b1);
    cycle(4'b0111, 4'b0000, 1'b1);
    cycle(4'b0111, 4'b0000, 1'b0);
    cycle(4'b0111, 4'b0001, 1'b1);
    cycle(4'b0111, 4'b0100, 1'b0);
    cycle(4'b0111, 4'b0100, 1'b1);
    cycle(4'b0111, 4'b0000, 1'b1);
    cycle(4'b0001, 4'b0001, 1'b1);

    // Source 1 gap mid-packet while source 3 waits.
    cycle(4'b1010, 4'b1000, 1'b1);
    cycle(4'b1010, 4'b1000, 1'b1);
    cycle(4'b1000, 4'b1000, 1'b1);
    cycle(4'b1000, 4'b1010, 1'b1);
    cycle(4'b1010, 4'b0010, 1'b1);
    cycle(4'b1000, 4'b1000, 1'b1);
    cycle(4'b1000, 4'b1000, 1'b1);

    // Wrap-around: only source 3 requests after its own packet.
    cycle(4'b1000, 4'b1000, 1'b1);
    cycle(4'b1000, 4'b1000, 1'b1);

    // Reset during beat 2 of a source-1 packet.
    cycle(4'b0010, 4'b0000, 1'b1);
    cycle(4'b0010, 4'b0000, 1'b1);
    cycle(4'b0010, 4'b0000, 1'b1);
    async_reset();
    cycle(4'b0011, 4'b0011, 1'b1);
    cycle(4'b0011, 4'b0011, 1'b1);
    cycle(4'b0011, 4'b0011, 1'b1);
    cycle(4'b0011, 4'b0011, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r = DEPTH'($urandom);
      l = '0;
      for (int b = 0; b < DEPTH; b++) l[b] = ($urandom_range(0, 2) == 0);
      cycle(r, l, $urandom_range(0, 3) != 0);
      if (n == 1500) async_reset();
    end

    cycle(4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    chk("cyc_q_drained", cyc_q.size(), 0);
    chk("xfer_q_drained", xfer_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- Round-robin, packet-locking arbiter that sits directly upstream of the team's parameterized mux.
- It generates the mux `select` and per-requester handshakes, so DEPTH sources can share one BIT_WIDTH datapath.
- A grant is held from the first beat of a packet until its last beat has transferred; then the next requester in round-robin order is served.

Parameters:
- DEPTH, 4, number of requesters (mux inputs); legal 2..32.
- SEL_WIDTH, log2(DEPTH), width of select; the same value the mux computes from its own DEPTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  DEPTH  per-source valid; bit i = source i has a beat on mux input i
- last  input  DEPTH  per-source end-of-packet flag; sampled only with that source's transferring beat
- ready_in  input  1  downstream accepts the mux output this cycle
- select  output  SEL_WIDTH  binary index driven to mux select (registered)
- grant  output  DEPTH  one-hot decode of select while LOCKED; all-zero in IDLE
- valid_out  output  1  mux output beat valid
- ready_out  output  DEPTH  per-source accept; bit i = grant[i] & ready_in
- busy  output  1  high in LOCKED

Behaviour:
- States: IDLE, LOCKED. Internal ptr (SEL_WIDTH) = last granted index.
- Reset (async, immediate):
  - state=IDLE, select=0, grant=0, valid_out=0, ready_out=0, busy=0.
  - ptr=DEPTH-1, so source 0 has first priority.
- IDLE:
  - valid_out=0, ready_out=0.
  - If any req bit is set, choose the first set index scanning ptr+1, ptr+2, … modulo DEPTH (wrap past DEPTH-1 to 0, not 2^SEL_WIDTH).
  - Register the winner into select and enter LOCKED at the next edge. Arbitration latency is 1 cycle; no beat transfers in the arbitration cycle.
  - If no req bit is set, stay in IDLE and hold select.
- LOCKED:
  - valid_out = req[select] (combinational); ready_out = grant & {DEPTH{ready_in}}.
  - Transfer occurs when valid_out & ready_in.
  - Transfer with last[select]=1: next state is IDLE, ptr<=select, grant drops next cycle.
  - Transfer with last=0, no transfer, or req[select] deasserted mid-packet: stay LOCKED on the same source. Gaps are allowed and other requesters are never served mid-packet.
- Requests from non-granted sources never affect select or ready_out while LOCKED.
- A requester may keep req high through IDLE after its last beat. It is re-granted only if it is the first set index after ptr in the scan.
- Single requester repeatedly: each packet costs 1 IDLE cycle between packets (throughput rule; no back-to-back bypass).
- select changes only on the IDLE→LOCKED edge, so the mux input is stable for the whole packet.
- last bits of non-granted sources are ignored. last without a transfer has no effect.
- Reset asserted mid-packet returns to IDLE immediately with ptr=DEPTH-1. The partial packet is abandoned, and the next arbitration starts from source 0.
- Outputs are glitch-free from registers except valid_out and ready_out, which are single-gate functions of registers and inputs.

Test Plan:
- Reset then req=4'b0000 for 5 cycles → grant=0, valid_out=0, busy=0, select=0 throughout.
- DEPTH=4, req=4'b1111, each source sends 1-beat packets (last=1), ready_in=1 → grant order 0,1,2,3,0, with one IDLE cycle between grants.
- Source 2 sends a 3-beat packet while ready_in toggles 1,0,1,0,1 and req=4'b0111 → select=2 held, exactly 3 transfers, grant released only after the 3rd; source 0 is granted next.
- Source 1 locked, drops req for 2 cycles mid-packet while req[3]=1 → valid_out=0 in the gap, select stays 1, and source 3 is not granted until source 1's last beat.
- ptr=3 (after a source-3 packet), req=4'b1000 only → wrap-around scan re-grants source 3 after one IDLE cycle.
- Assert rst during beat 2 of a source-1 packet → all outputs 0 asynchronously; after release with req=4'b0011, source 0 is granted first.
